// File: rtl/core_power_sequencer_if.sv
// Control/status bundle between a node's self-awareness logic and the
// power sequencer of its processor domain.
interface core_power_sequencer_if #(
   parameter int CNT_W = 32
);
   logic             activate;
   logic             bus_idle;
   logic             cnt_clr;
   logic             clk_en;
   logic             core_res_n;
   logic             running;
   logic             done;
   logic             drain_timeout;
   logic [CNT_W-1:0] active_cycles;

   // The requester drives the controls and observes the sequencer status.
   modport master (
      output activate, bus_idle, cnt_clr,
      input  clk_en, core_res_n, running, done, drain_timeout, active_cycles
   );

   // The sequencer consumes the controls and produces the status.
   modport slave (
      input  activate, bus_idle, cnt_clr,
      output clk_en, core_res_n, running, done, drain_timeout, active_cycles
   );
endinterface

// File: rtl/core_power_sequencer.sv
// Power sequencer for one processor domain: on wake the clock runs with the
// core held in reset before release; on sleep the core AXI port is drained
// (with a bounded wait), reset is asserted with the clock still running and
// only then is the clock stopped. Also counts clock-enabled cycles.
module core_power_sequencer #(
   parameter int RES_HOLD      = 4,
   parameter int RES_PRE       = 2,
   parameter int DRAIN_TIMEOUT = 256,
   parameter int CNT_W         = 32
) (
   input  logic                 clk,
   input  logic                 res,
   core_power_sequencer_if.slave bus
);

   localparam int MAX_A = (RES_HOLD > RES_PRE) ? RES_HOLD : RES_PRE;
   localparam int MAX_V = (MAX_A > DRAIN_TIMEOUT) ? MAX_A : DRAIN_TIMEOUT;
   localparam int SEQ_W = $clog2(MAX_V) + 1;

   localparam logic [SEQ_W-1:0] SEQ_ONE   = SEQ_W'(1);
   localparam logic [SEQ_W-1:0] SEQ_HOLD  = SEQ_W'(RES_HOLD);
   localparam logic [SEQ_W-1:0] SEQ_PRE   = SEQ_W'(RES_PRE);
   localparam logic [SEQ_W-1:0] SEQ_DRAIN = SEQ_W'(DRAIN_TIMEOUT);

   typedef enum logic [2:0] {
      ST_OFF,
      ST_WAKE,
      ST_RUN,
      ST_DRAIN,
      ST_QUIESCE
   } state_t;

   state_t           state;
   logic [SEQ_W-1:0] seq_cnt;
   logic             clk_en_q;
   logic             core_res_n_q;
   logic             running_q;
   logic             done_q;
   logic             drain_timeout_q;
   logic [CNT_W-1:0] active_cycles_q;

   assign bus.clk_en        = clk_en_q;
   assign bus.core_res_n    = core_res_n_q;
   assign bus.running       = running_q;
   assign bus.done          = done_q;
   assign bus.drain_timeout = drain_timeout_q;
   assign bus.active_cycles = active_cycles_q;

   // Sequencing FSM; every output is updated together with the state it
   // belongs to, so the outputs always reflect the registered state.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state           <= ST_OFF;
         seq_cnt         <= '0;
         clk_en_q        <= 1'b0;
         core_res_n_q    <= 1'b0;
         running_q       <= 1'b0;
         done_q          <= 1'b0;
         drain_timeout_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_OFF: begin
               if (bus.activate) begin
                  state           <= ST_WAKE;
                  seq_cnt         <= SEQ_HOLD;
                  clk_en_q        <= 1'b1;
                  core_res_n_q    <= 1'b0;
                  drain_timeout_q <= 1'b0;
               end
            end
            ST_WAKE: begin
               if (seq_cnt == SEQ_ONE) begin
                  state        <= ST_RUN;
                  core_res_n_q <= 1'b1;
                  running_q    <= 1'b1;
               end else begin
                  seq_cnt <= seq_cnt - SEQ_ONE;
               end
            end
            ST_RUN: begin
               if (!bus.activate) begin
                  state     <= ST_DRAIN;
                  seq_cnt   <= SEQ_DRAIN;
                  running_q <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (bus.bus_idle) begin
                  state        <= ST_QUIESCE;
                  seq_cnt      <= SEQ_PRE;
                  core_res_n_q <= 1'b0;
               end else if (seq_cnt == SEQ_ONE) begin
                  state           <= ST_QUIESCE;
                  seq_cnt         <= SEQ_PRE;
                  core_res_n_q    <= 1'b0;
                  drain_timeout_q <= 1'b1;
               end else begin
                  seq_cnt <= seq_cnt - SEQ_ONE;
               end
            end
            ST_QUIESCE: begin
               if (seq_cnt == SEQ_ONE) begin
                  state    <= ST_OFF;
                  clk_en_q <= 1'b0;
                  done_q   <= 1'b1;
               end else begin
                  seq_cnt <= seq_cnt - SEQ_ONE;
               end
            end
            default: begin
               state        <= ST_OFF;
               seq_cnt      <= '0;
               clk_en_q     <= 1'b0;
               core_res_n_q <= 1'b0;
               running_q    <= 1'b0;
            end
         endcase
      end
   end

   // Saturating count of clock-enabled cycles; a clear request overrides
   // any increment on the same edge.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         active_cycles_q <= '0;
      end else if (bus.cnt_clr) begin
         active_cycles_q <= '0;
      end else if (clk_en_q && (active_cycles_q != {CNT_W{1'b1}})) begin
         active_cycles_q <= active_cycles_q + CNT_W'(1);
      end
   end

endmodule
